// File: rtl/ukf_weighted_mean_if.sv
`default_nettype none
// ============================================================================
// Module   : ukf_weighted_mean_if
// Purpose  : Sigma-point input stream and weighted-mean output stream
//            bundled for the UKF weighted-mean accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface ukf_weighted_mean_if #(
  parameter int DATA_W = 32
) ();
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  // Producer of sigma points / consumer of the mean
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  // The accumulator itself
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface
`default_nettype wire

// File: rtl/ukf_weighted_mean.sv
`default_nettype none
// ============================================================================
// Module   : ukf_weighted_mean
// Purpose  : Accumulates 2*N_STATE+1 sigma points, each scaled by its mean
//            weight (2*w0m for point 0, w otherwise), and streams out the
//            N_STATE-element weighted mean.
//            Optional macro UKF_MEAN_SAT_EN: saturate outputs to DATA_W and
//            flag it on ovf; otherwise outputs wrap and ovf stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module ukf_weighted_mean #(
  parameter int N_STATE = 6,
  parameter int DATA_W  = 32,
  parameter int W_FRAC  = 30,
  parameter int ACC_W   = 40
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              start,
  input  wire logic [DATA_W-1:0] w0m,
  input  wire logic [DATA_W-1:0] w,
  ukf_weighted_mean_if.slave     sif,
  output logic                   busy,
  output logic                   ovf
);

  localparam int N_PTS  = 2 * N_STATE + 1;
  localparam int E_W    = (N_STATE > 1) ? $clog2(N_STATE) : 1;
  localparam int P_W    = $clog2(N_PTS);
  localparam int PROD_W = 2 * DATA_W + 2;
  localparam logic [E_W-1:0] E_LAST = E_W'(N_STATE - 1);
  localparam logic [P_W-1:0] P_LAST = P_W'(N_PTS - 1);

`ifdef UKF_MEAN_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [E_W-1:0]           e_q, e_d;
  logic [P_W-1:0]           p_q, p_d;
  logic [E_W-1:0]           k_q, k_d;
  logic [DATA_W-1:0]        w0m_q, w0m_d;
  logic [DATA_W-1:0]        w_q, w_d;
  logic signed [ACC_W-1:0]  acc_q [N_STATE];
  logic signed [ACC_W-1:0]  acc_d [N_STATE];
  logic                     m_valid_q, m_valid_d;
  logic [DATA_W-1:0]        m_data_q, m_data_d;
  logic                     m_last_q, m_last_d;
  logic                     ovf_q, ovf_d;

  logic [DATA_W:0]          weight;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  term;
  logic [E_W-1:0]           out_idx;
  logic                     load_out;
  logic [DATA_W:0]          red;

  // Narrow an accumulator to an output word; MSB of the result is the
  // saturation flag.
  function automatic logic [DATA_W:0] reduce(input logic signed [ACC_W-1:0] a);
`ifdef UKF_MEAN_SAT_EN
    if (a > SAT_HI)      return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    else if (a < SAT_LO) return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else                 return {1'b0, DATA_W'(a)};
`else
    return {1'b0, DATA_W'(a)};
`endif
  endfunction

  // Next-state, accumulation and output-register loading
  always_comb begin
    state_d   = state_q;
    e_d       = e_q;
    p_d       = p_q;
    k_d       = k_q;
    w0m_d     = w0m_q;
    w_d       = w_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    ovf_d     = ovf_q;
    for (int i = 0; i < N_STATE; i++) acc_d[i] = acc_q[i];
    out_idx   = '0;
    load_out  = 1'b0;

    // Point 0 uses the doubled (pre-halved upstream) weight; one extra bit
    // keeps the doubling lossless.
    weight = (p_q == '0) ? {w0m_q, 1'b0} : {1'b0, w_q};
    prod   = PROD_W'($signed(sif.s_data)) * PROD_W'($signed({1'b0, weight}));
    term   = ACC_W'(prod >>> W_FRAC);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          w0m_d   = w0m;
          w_d     = w;
          e_d     = '0;
          p_d     = '0;
          k_d     = '0;
          ovf_d   = 1'b0;
          for (int i = 0; i < N_STATE; i++) acc_d[i] = '0;
        end
      end
      ST_ACCUM: begin
        if (sif.s_valid) begin
          acc_d[e_q] = acc_q[e_q] + term;
          if (e_q == E_LAST) begin
            e_d = '0;
            p_d = p_q + P_W'(1);
            if (p_q == P_LAST) begin
              state_d  = ST_OUTPUT;
              p_d      = '0;
              k_d      = '0;
              load_out = 1'b1;
            end
          end else begin
            e_d = e_q + E_W'(1);
          end
        end
      end
      ST_OUTPUT: begin
        // m_valid is always high in this state
        if (sif.m_ready) begin
          if (k_q == E_LAST) begin
            state_d   = ST_IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
          end else begin
            k_d      = k_q + E_W'(1);
            out_idx  = k_q + E_W'(1);
            load_out = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reduce from the next-cycle accumulator so the final input beat is
    // already included when element 0 is loaded.
    red = reduce(acc_d[out_idx]);
    if (load_out) begin
      m_valid_d = 1'b1;
      m_data_d  = red[DATA_W-1:0];
      m_last_d  = (out_idx == E_LAST);
      ovf_d     = ovf_d | red[DATA_W];
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      e_q       <= '0;
      p_q       <= '0;
      k_q       <= '0;
      w0m_q     <= '0;
      w_q       <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < N_STATE; i++) acc_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      e_q       <= e_d;
      p_q       <= p_d;
      k_q       <= k_d;
      w0m_q     <= w0m_d;
      w_q       <= w_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      ovf_q     <= ovf_d;
      for (int i = 0; i < N_STATE; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign sif.s_ready = (state_q == ST_ACCUM);
  assign sif.m_valid = m_valid_q;
  assign sif.m_data  = m_data_q;
  assign sif.m_last  = m_last_q;
  assign busy        = (state_q != ST_IDLE);
  assign ovf         = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ukf_weighted_mean.sv
`default_nettype none
// ============================================================================
// Module   : tb_ukf_weighted_mean
// Purpose  : Self-checking bench for ukf_weighted_mean: directed vector table,
//            handshake / reset sequences and random runs against a
//            big-integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ukf_weighted_mean;

  localparam int N  = 6;
  localparam int DW = 32;
  localparam int NB = (2 * N + 1) * N;
  localparam logic signed [127:0] SCALE = 128'sd1073741824;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] w0m;
  logic [DW-1:0] w;
  logic          busy;
  logic          ovf;

  ukf_weighted_mean_if #(.DATA_W(DW)) sif ();

  ukf_weighted_mean #(
    .N_STATE(N), .DATA_W(DW), .W_FRAC(30), .ACC_W(40)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .w0m(w0m), .w(w),
    .sif(sif), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int errors;
  int checks;

  logic [31:0] sig [NB];
  logic [31:0] exp_m [N];
  logic        exp_ovf;
  logic [31:0] got [N];
  logic [N-1:0] got_last;
  bit          stable_ok, lat_ok, sr_ok, timed_out;
  logic        end_busy, end_mvalid, end_ovf;

  typedef struct {
    string       name;
    logic [31:0] w0m;
    logic [31:0] w;
    int          mode;   // 0 all elements, 1 point 0 only, 2 point 1 element 0 only
    logic [31:0] val;
    logic [31:0] exp0;
    logic [31:0] exp_rest;
    logic        eovf;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  function automatic void fill(input int mode, input logic [31:0] val);
    for (int i = 0; i < NB; i++) begin
      case (mode)
        0:       sig[i] = val;
        1:       sig[i] = (i < N) ? val : 32'h0;
        default: sig[i] = (i == N) ? val : 32'h0;
      endcase
    end
  endfunction

  // Reference: exact products in wide integers, floor division by 2^30,
  // totals wrapped to 40 bits, then narrowed to 32 bits.
  function automatic void model(input logic [31:0] w0m_i, input logic [31:0] w_i);
    logic signed [127:0] sum [N];
    logic signed [127:0] x, wt, prod, q;
    logic signed [31:0]  xs;
    logic signed [39:0]  a;
`ifdef UKF_MEAN_SAT_EN
    longint la;
`endif
    exp_ovf = 1'b0;
    for (int e = 0; e < N; e++) sum[e] = 0;
    for (int p = 0; p < 2 * N + 1; p++) begin
      for (int e = 0; e < N; e++) begin
        xs   = sig[p * N + e];
        x    = xs;
        wt   = (p == 0) ? 128'(w0m_i) * 2 : 128'(w_i);
        prod = x * wt;
        q    = prod / SCALE;
        if (prod < 0 && (prod % SCALE) != 0) q = q - 1;
        sum[e] = sum[e] + q;
      end
    end
    for (int e = 0; e < N; e++) begin
      a = sum[e][39:0];
`ifdef UKF_MEAN_SAT_EN
      la = a;
      if (la > 64'sd2147483647) begin
        exp_m[e] = 32'h7FFFFFFF; exp_ovf = 1'b1;
      end else if (la < -64'sd2147483648) begin
        exp_m[e] = 32'h80000000; exp_ovf = 1'b1;
      end else begin
        exp_m[e] = a[31:0];
      end
`else
      exp_m[e] = a[31:0];
`endif
    end
  endfunction

  // One run: start pulse, feed sig[] with optional gaps, drain outputs with
  // optional stalls. abort_at >= 0 stops feeding after that many beats.
  task automatic do_run(input logic [31:0] w0m_i, input logic [31:0] w_i,
                        input int gap_pct, input int stall_pct,
                        input bit dbl_start, input int abort_at);
    int idx, nout, cyc, last_in_cyc, first_mv_cyc;
    bit held;
    logic [31:0] held_d;
    logic held_l;
    idx = 0; nout = 0; cyc = 0; last_in_cyc = -1; first_mv_cyc = -1;
    held = 0; held_d = 0; held_l = 0;
    stable_ok = 1; timed_out = 0; got_last = '0;
    for (int i = 0; i < N; i++) got[i] = 32'hDEADBEEF;

    @(negedge clk);
    start = 1'b1; w0m = w0m_i; w = w_i;
    sr_ok = (sif.s_ready == 1'b0);
    @(negedge clk);
    start = 1'b0; w0m = $urandom; w = $urandom;
    sr_ok = sr_ok && (sif.s_ready == 1'b1);

    while (nout < N) begin
      if (cyc > 3000) begin
        timed_out = 1;
        break;
      end
      if (held && !(sif.m_valid && sif.m_data == held_d && sif.m_last == held_l))
        stable_ok = 0;
      if (sif.m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
      sif.m_ready = ($urandom_range(99) >= stall_pct);
      held = 0;
      if (sif.m_valid) begin
        if (sif.m_ready) begin
          got[nout] = sif.m_data;
          got_last[nout] = sif.m_last;
          nout++;
        end else begin
          held = 1; held_d = sif.m_data; held_l = sif.m_last;
        end
      end
      if (abort_at >= 0 && idx == abort_at) break;
      if (idx < NB && $urandom_range(99) >= gap_pct) begin
        sif.s_valid = 1'b1;
        sif.s_data  = sig[idx];
        if (sif.s_ready) begin
          idx++;
          if (idx == NB) last_in_cyc = cyc;
        end
      end else begin
        sif.s_valid = 1'b0;
        sif.s_data  = $urandom;
      end
      start = dbl_start && (cyc == 25) && (idx < NB);
      @(negedge clk);
      cyc++;
    end
    sif.s_valid = 1'b0;
    start = 1'b0;
    lat_ok = (first_mv_cyc == last_in_cyc + 1);
    if (abort_at < 0 && !timed_out) begin
      @(negedge clk);
      end_busy = busy; end_mvalid = sif.m_valid; end_ovf = ovf;
    end
    sif.m_ready = 1'b0;
  endtask

  task automatic check_run(input string nm);
    chk({nm, "_timeout"}, 64'(timed_out), 64'd0);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_out%0d", nm, i), 64'(got[i]), 64'(exp_m[i]));
    chk({nm, "_mlast"}, 64'(got_last), 64'(6'b100000));
    chk({nm, "_stable"}, 64'(stable_ok), 64'd1);
    chk({nm, "_latency"}, 64'(lat_ok), 64'd1);
    chk({nm, "_sready_rise"}, 64'(sr_ok), 64'd1);
    chk({nm, "_ovf"}, 64'(end_ovf), 64'(exp_ovf));
    chk({nm, "_idle_after"}, 64'({end_busy, end_mvalid}), 64'd0);
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; start = 1'b0; w0m = '0; w = '0;
    sif.s_valid = 1'b0; sif.s_data = '0; sif.m_ready = 1'b0;
    end_busy = 1'b1; end_mvalid = 1'b1; end_ovf = 1'b1;

    vecs[0] = '{"uniform",  32'h0,        32'h05555555, 0, 32'h000C0000,
                32'h000BFFF4, 32'h000BFFF4, 1'b0};
    vecs[1] = '{"point0",   32'h08000000, 32'h0AAAAAAB, 1, 32'h00010000,
                32'h00004000, 32'h00004000, 1'b0};
    vecs[2] = '{"negfloor", 32'h0,        32'h40000000, 2, 32'hFFFFFFFF,
                32'hFFFFFFFF, 32'h00000000, 1'b0};
`ifdef UKF_MEAN_SAT_EN
    vecs[3] = '{"overflow", 32'h0,        32'h40000000, 0, 32'h7FFFFFFF,
                32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1};
`else
    vecs[3] = '{"overflow", 32'h0,        32'h40000000, 0, 32'h7FFFFFFF,
                32'hFFFFFFF4, 32'hFFFFFFF4, 1'b0};
`endif

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 64'(sif.s_ready), 64'd0);
    chk("rst_m_valid", 64'(sif.m_valid), 64'd0);
    chk("rst_m_data",  64'(sif.m_data),  64'd0);
    chk("rst_m_last",  64'(sif.m_last),  64'd0);
    chk("rst_busy",    64'(busy),        64'd0);
    chk("rst_ovf",     64'(ovf),         64'd0);
    rst = 1'b0;

    // s_valid while idle must not start anything
    sif.s_valid = 1'b1; sif.s_data = 32'h12345678;
    repeat (3) @(negedge clk);
    chk("idle_svalid_busy", 64'({busy, sif.s_ready}), 64'd0);
    sif.s_valid = 1'b0;

    // Directed table at full rate
    for (int v = 0; v < 4; v++) begin
      fill(vecs[v].mode, vecs[v].val);
      exp_m[0] = vecs[v].exp0;
      for (int i = 1; i < N; i++) exp_m[i] = vecs[v].exp_rest;
      exp_ovf = vecs[v].eovf;
      do_run(vecs[v].w0m, vecs[v].w, 0, 0, 1'b0, -1);
      check_run(vecs[v].name);
    end

    // Gaps, stalls and a second start during accumulation
    fill(0, 32'h000C0000);
    for (int i = 0; i < N; i++) exp_m[i] = 32'h000BFFF4;
    exp_ovf = 1'b0;
    do_run(32'h0, 32'h05555555, 40, 50, 1'b1, -1);
    check_run("handshake");

    // Reset in the middle of accumulation, then a clean run
    do_run(32'h0, 32'h05555555, 0, 0, 1'b0, 40);
    rst = 1'b1;
    #1;
    chk("midrst_s_ready", 64'(sif.s_ready), 64'd0);
    chk("midrst_busy",    64'(busy),        64'd0);
    chk("midrst_m_valid", 64'(sif.m_valid), 64'd0);
    @(negedge clk);
    chk("midrst_s_ready_hold", 64'(sif.s_ready), 64'd0);
    rst = 1'b0;
    do_run(32'h0, 32'h05555555, 0, 0, 1'b0, -1);
    check_run("after_rst");

    // Random runs against the reference model
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NB; i++) begin
        if (r % 2 == 0) sig[i] = $urandom;
        else            sig[i] = 32'($signed(16'($urandom)));
      end
      begin
        logic [31:0] rw0m, rw;
        rw0m = (r % 2 == 0) ? 32'($urandom) : 32'($urandom_range(32'h10000000));
        rw   = (r % 2 == 0) ? 32'($urandom) : 32'($urandom_range(32'h10000000));
        model(rw0m, rw);
        do_run(rw0m, rw, 30, 30, r[0], -1);
      end
      check_run($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ukf_weighted_mean.md
# ukf_weighted_mean

Weighted-mean accumulator for the UKF predict/update path. Consumes the sigma-point stream (2·N_STATE+1 points, N_STATE elements each) and applies the mean weights produced by the weight-calculation stage (w0m for point 0, w for points 1..2L). It then streams out the N_STATE-element weighted mean. It sits directly downstream of the weight calculator and upstream of the covariance stage.

## Interface
- N_STATE, 6, state dimension L; points per run = 2L+1
- DATA_W, 32, width of sigma elements, weights and mean outputs
- W_FRAC, 30, fractional bits of weights (unsigned Q2.30)
- ACC_W, 40, signed accumulator width (≥ DATA_W+8)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  pulse; latches w0m/w and begins a run (honoured only in IDLE)
- w0m  in  DATA_W  point-0 mean weight, unsigned Q2.30, pre-halved upstream
- w  in  DATA_W  weight for points 1..2L, unsigned Q2.30
- s_valid  in  1  sigma element valid
- s_ready  out  1  block accepts sigma element
- s_data  in  DATA_W  sigma element, signed two's complement (any Q format; output keeps it)
- m_valid  out  1  mean element valid
- m_ready  in  1  consumer accepts mean element
- m_data  out  DATA_W  mean element, signed, same Q format as s_data
- m_last  out  1  high with element N_STATE-1
- busy  out  1  high in ACCUM or OUTPUT
- ovf  out  1  sticky per run: some output element saturated

## Operation
- FSM: IDLE → (start) ACCUM → (last input beat accepted) OUTPUT → (last output beat accepted) IDLE.
- On start in IDLE: latch w0m, w; clear all N_STATE accumulators, element index e, point index p, ovf. start in other states is ignored.
- Input order: point-major. Point p = 0..2L, element e = 0..N-1 within each point. s_ready = 1 only in ACCUM.
- Per accepted beat: weight = (p==0) ? 2·w0m (left shift, DATA_W+1 bits, no overflow) : w. prod = s_data (signed) × weight (unsigned, zero-extended). Then term = prod >>> W_FRAC (arithmetic, floor). acc[e] += term, wrapping at ACC_W.
- Index update: e wraps N-1→0 and increments p; the beat with p=2L, e=N-1 moves to OUTPUT.
- OUTPUT: element index k = 0..N-1. m_data = reduce(acc[k]) (see Configuration). m_last = (k==N-1). k advances on m_valid & m_ready.
- ovf is set when any output element is saturated and holds until next start.

## Timing
- Reset: state IDLE, s_ready=0, m_valid=0, m_data=0, m_last=0, busy=0, ovf=0, accumulators, indices and latched weights 0.
- s_ready rises the cycle after start is sampled. One element accepted per cycle at full rate; 13·6 = 78 beats minimum for defaults.
- m_valid asserts the cycle after the final input beat is accepted. m_data/m_last are registered and held stable while m_valid & !m_ready.
- N outputs in N cycles with m_ready=1. IDLE is re-entered the cycle after the m_last beat is accepted; start is honoured from that cycle.
- s_valid in IDLE/OUTPUT: ignored, no state change.
- rst mid-run: immediate return to reset values; partial sums are discarded.

## Configuration
- UKF_MEAN_SAT_EN defined: outputs saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1] when acc[k] exceeds the DATA_W range; ovf is sticky as above.
- Undefined: m_data = acc[k][DATA_W−1:0] (wrap); ovf tied 0.

## Test plan
- Uniform: w0m=0, w=0x05555555, all 78 elements 0x000C0000 → each term 0xFFFF, all 6 outputs 0x000BFFF4, m_last on 6th, ovf=0.
- Point-0 only: w0m=0x08000000, w=0x0AAAAAAB, point 0 elements 0x00010000, others 0 → all outputs 0x00004000.
- Negative floor: w0m=0, w=0x40000000, element 0 = 0xFFFFFFFF on point 1 only, rest 0 → output0 0xFFFFFFFF, outputs1..5 0.
- Overflow: w0m=0, w=0x40000000, all elements 0x7FFFFFFF → with UKF_MEAN_SAT_EN: 0x7FFFFFFF ×6, ovf=1. Without: 0xFFFFFFF4 ×6, ovf=0.
- Handshake: random s_valid gaps and m_ready stalls; start pulsed during ACCUM → results identical to full-rate run. m_data stable during stall, second start ignored.
- Reset mid-run: assert rst after 40 input beats, release, new start with the uniform case → s_ready=0 during rst, result 0x000BFFF4 (no residue).
